// File: rtl/fifo_pkg.sv
// Shared FIFO/LIFO constants: default geometry, pointer width helper, flag-vector bit positions.
package fifo_pkg;

    localparam int FIFO_ADDR_W_DEFAULT = 4;

    localparam int FLAG_FULL   = 0;
    localparam int FLAG_EMPTY  = 1;
    localparam int FLAG_AFULL  = 2;
    localparam int FLAG_AEMPTY = 3;
    localparam int FLAG_OVF    = 4;
    localparam int FLAG_UNF    = 5;
    localparam int FLAG_NUM    = 6;

    // Pointers carry one extra wrap bit above the memory address.
    function automatic int ptr_w(input int addr_w);
        return addr_w + 1;
    endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Wrap-bit pointer: ADDR_W address bits plus MSB wrap flag, advances by one when enabled.
// Latency: new value visible the cycle after en; no backpressure of its own.
module fifo_ptr
    import fifo_pkg::*;
#(
    parameter int ADDR_W = FIFO_ADDR_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_edge,
    input  logic              en,
    output logic [ADDR_W:0]   ptr_ext
);

    localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};

    always_ff @(posedge clk) begin
        if (rst_edge) begin
            ptr_ext <= '0;
        end else if (en) begin
            ptr_ext <= ptr_ext + PTR_ONE;
        end
    end

endmodule

// File: rtl/fifo_ptr_ctrl.sv
// FIFO pointer controller: gated memory enables/addresses, occupancy count, full/empty/almost flags.
// Latency: enables combinational with strobes; pointers, count and flags update on the next edge.
// Backpressure: pushes dropped while full, pops dropped while empty; sticky errors with FIFO_ERR_FLAGS_EN.
module fifo_ptr_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_W    = FIFO_ADDR_W_DEFAULT,
    parameter int AFULL_TH  = (2 ** ADDR_W) - 2,
    parameter int AEMPTY_TH = 2
) (
    input  logic              clk,
    input  logic              rst_edge,
    input  logic              wr_edge,
    input  logic              rd_edge,
    input  logic              err_clr,
    output logic              fifo_we,
    output logic              fifo_re,
    output logic [ADDR_W-1:0] wptr,
    output logic [ADDR_W-1:0] rptr,
    output logic [ADDR_W:0]   fifo_count,
    output logic              fifo_full,
    output logic              fifo_empty,
    output logic              fifo_afull,
    output logic              fifo_aempty,
    output logic              fifo_overflow,
    output logic              fifo_underflow
);

    localparam int              PW        = ptr_w(ADDR_W);
    localparam logic [ADDR_W:0] DEPTH_V   = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0] AFULL_V   = AFULL_TH[ADDR_W:0];
    localparam logic [ADDR_W:0] AEMPTY_V  = AEMPTY_TH[ADDR_W:0];

    logic [PW-1:0]       wext;
    logic [PW-1:0]       rext;
    logic [FLAG_NUM-1:0] flags;

    assign fifo_we = wr_edge & ~fifo_full;
    assign fifo_re = rd_edge & ~fifo_empty;

    fifo_ptr #(.ADDR_W(ADDR_W)) u_wr_ptr (
        .clk      (clk),
        .rst_edge (rst_edge),
        .en       (fifo_we),
        .ptr_ext  (wext)
    );

    fifo_ptr #(.ADDR_W(ADDR_W)) u_rd_ptr (
        .clk      (clk),
        .rst_edge (rst_edge),
        .en       (fifo_re),
        .ptr_ext  (rext)
    );

    assign wptr = wext[ADDR_W-1:0];
    assign rptr = rext[ADDR_W-1:0];

    always_ff @(posedge clk) begin
        if (rst_edge) begin
            fifo_count <= '0;
        end else begin
            case ({fifo_we, fifo_re})
                2'b10:   fifo_count <= fifo_count + CNT_ONE;
                2'b01:   fifo_count <= fifo_count - CNT_ONE;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Full/empty come from the pointers; the count only feeds the almost thresholds.
    assign flags[FLAG_FULL]   = (wext[ADDR_W] != rext[ADDR_W]) &&
                                (wext[ADDR_W-1:0] == rext[ADDR_W-1:0]);
    assign flags[FLAG_EMPTY]  = (wext == rext);
    assign flags[FLAG_AFULL]  = (fifo_count >= AFULL_V);
    assign flags[FLAG_AEMPTY] = (fifo_count <= AEMPTY_V);

`ifdef FIFO_ERR_FLAGS_EN
    logic ovf_q;
    logic unf_q;

    // A fresh error in the same cycle as err_clr keeps the flag set.
    always_ff @(posedge clk) begin
        if (rst_edge) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            if (wr_edge && fifo_full)       ovf_q <= 1'b1;
            else if (err_clr)               ovf_q <= 1'b0;
            if (rd_edge && fifo_empty)      unf_q <= 1'b1;
            else if (err_clr)               unf_q <= 1'b0;
        end
    end

    assign flags[FLAG_OVF] = ovf_q;
    assign flags[FLAG_UNF] = unf_q;
`else
    logic unused_err_clr;
    assign unused_err_clr  = err_clr;
    assign flags[FLAG_OVF] = 1'b0;
    assign flags[FLAG_UNF] = 1'b0;
`endif

    assign fifo_full      = flags[FLAG_FULL];
    assign fifo_empty     = flags[FLAG_EMPTY];
    assign fifo_afull     = flags[FLAG_AFULL];
    assign fifo_aempty    = flags[FLAG_AEMPTY];
    assign fifo_overflow  = flags[FLAG_OVF];
    assign fifo_underflow = flags[FLAG_UNF];

    a_flags_match_count: assert property (@(posedge clk) disable iff (rst_edge)
        (fifo_full == (fifo_count == DEPTH_V)) && (fifo_empty == (fifo_count == '0)));

endmodule

// File: tb/tb_fifo_ptr_ctrl.sv
// Directed bench for fifo_ptr_ctrl (ADDR_W=4): occupancy model checked every cycle plus literal anchors.
module tb_fifo_ptr_ctrl;

    logic       clk = 1'b0;
    logic       rst_edge = 1'b0;
    logic       wr_edge = 1'b0;
    logic       rd_edge = 1'b0;
    logic       err_clr = 1'b0;
    logic       fifo_we, fifo_re;
    logic [3:0] wptr, rptr;
    logic [4:0] fifo_count;
    logic       fifo_full, fifo_empty, fifo_afull, fifo_aempty;
    logic       fifo_overflow, fifo_underflow;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Model: occupancy plus total accepted pushes/pops; addresses are totals mod 16.
    int m_cnt = 0;
    int m_wtot = 0;
    int m_rtot = 0;
    bit m_ovf = 1'b0;
    bit m_unf = 1'b0;

    fifo_ptr_ctrl #(.ADDR_W(4), .AFULL_TH(14), .AEMPTY_TH(2)) dut (
        .clk            (clk),
        .rst_edge       (rst_edge),
        .wr_edge        (wr_edge),
        .rd_edge        (rd_edge),
        .err_clr        (err_clr),
        .fifo_we        (fifo_we),
        .fifo_re        (fifo_re),
        .wptr           (wptr),
        .rptr           (rptr),
        .fifo_count     (fifo_count),
        .fifo_full      (fifo_full),
        .fifo_empty     (fifo_empty),
        .fifo_afull     (fifo_afull),
        .fifo_aempty    (fifo_aempty),
        .fifo_overflow  (fifo_overflow),
        .fifo_underflow (fifo_underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (rst_edge) begin
            m_cnt = 0; m_wtot = 0; m_rtot = 0; m_ovf = 1'b0; m_unf = 1'b0;
        end else begin
            automatic bit acc_w = wr_edge && (m_cnt < 16);
            automatic bit acc_r = rd_edge && (m_cnt > 0);
`ifdef FIFO_ERR_FLAGS_EN
            if (wr_edge && m_cnt == 16) m_ovf = 1'b1;
            else if (err_clr)           m_ovf = 1'b0;
            if (rd_edge && m_cnt == 0)  m_unf = 1'b1;
            else if (err_clr)           m_unf = 1'b0;
`endif
            m_cnt  = m_cnt + int'(acc_w) - int'(acc_r);
            m_wtot = m_wtot + int'(acc_w);
            m_rtot = m_rtot + int'(acc_r);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("we",        int'(fifo_we),        int'(wr_edge && m_cnt != 16));
            chk("re",        int'(fifo_re),        int'(rd_edge && m_cnt != 0));
            chk("wptr",      int'(wptr),           m_wtot % 16);
            chk("rptr",      int'(rptr),           m_rtot % 16);
            chk("count",     int'(fifo_count),     m_cnt);
            chk("full",      int'(fifo_full),      int'(m_cnt == 16));
            chk("empty",     int'(fifo_empty),     int'(m_cnt == 0));
            chk("afull",     int'(fifo_afull),     int'(m_cnt >= 14));
            chk("aempty",    int'(fifo_aempty),    int'(m_cnt <= 2));
            chk("overflow",  int'(fifo_overflow),  int'(m_ovf));
            chk("underflow", int'(fifo_underflow), int'(m_unf));
        end
    end

    // One clock with the given strobes; returns 1 time unit after the edge.
    task automatic cyc(input bit w, input bit r, input bit c, input bit rst);
        wr_edge = w; rd_edge = r; err_clr = c; rst_edge = rst;
        @(posedge clk);
        #1;
        wr_edge = 1'b0; rd_edge = 1'b0; err_clr = 1'b0; rst_edge = 1'b0;
    endtask

    initial begin
        bit exp_err;
`ifdef FIFO_ERR_FLAGS_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        #2;
        cyc(0, 0, 0, 1);
        chk_en = 1'b1;
        chk("reset count",  int'(fifo_count), 0);
        chk("reset empty",  int'(fifo_empty), 1);
        chk("reset aempty", int'(fifo_aempty), 1);

        // Fill: afull from 14, aempty drops at 3, full at 16, wptr wraps to 0.
        for (int i = 0; i < 16; i++) cyc(1, 0, 0, 0);
        chk("fill count", int'(fifo_count), 16);
        chk("fill full",  int'(fifo_full), 1);
        chk("fill wptr",  int'(wptr), 0);

        // Push while full is dropped.
        cyc(1, 0, 0, 0);
        chk("ovf count", int'(fifo_count), 16);
        chk("ovf flag",  int'(fifo_overflow), int'(exp_err));
        cyc(0, 0, 1, 0);
        chk("ovf cleared", int'(fifo_overflow), 0);

        // Full with push+pop: pop only.
        cyc(1, 1, 0, 0);
        chk("full both count", int'(fifo_count), 15);
        chk("full both rptr",  int'(rptr), 1);
        chk("full both wptr",  int'(wptr), 0);

        // Drain, then pop from empty.
        for (int i = 0; i < 15; i++) cyc(0, 1, 0, 0);
        chk("drain empty", int'(fifo_empty), 1);
        cyc(0, 1, 0, 0);
        chk("unf rptr", int'(rptr), 0);
        chk("unf flag", int'(fifo_underflow), int'(exp_err));
        // Fresh error beats err_clr in the same cycle.
        cyc(0, 1, 1, 0);
        chk("unf set wins", int'(fifo_underflow), int'(exp_err));
        cyc(0, 0, 1, 0);
        chk("unf cleared", int'(fifo_underflow), 0);

        // Empty with push+pop: push only.
        cyc(1, 1, 0, 0);
        chk("empty both count", int'(fifo_count), 1);
        chk("empty both wptr",  int'(wptr), 1);
        chk("empty both rptr",  int'(rptr), 0);

        // Steady state at count 5 across pointer wrap.
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0);
        for (int i = 0; i < 20; i++) cyc(1, 1, 0, 0);
        chk("steady count", int'(fifo_count), 5);
        chk("steady wptr",  int'(wptr), 9);
        chk("steady rptr",  int'(rptr), 4);

        // Reset mid-operation with push strobe high.
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0);
        chk("pre-reset count", int'(fifo_count), 9);
        cyc(1, 0, 0, 1);
        chk("mid reset count", int'(fifo_count), 0);
        chk("mid reset wptr",  int'(wptr), 0);
        chk("mid reset empty", int'(fifo_empty), 1);
        cyc(0, 0, 0, 0);

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
